// File: rtl/servo_cmd_master_if.sv
// rtl/servo_cmd_master_if.sv - command stream and Avalon-MM write bus for servo_cmd_master
interface servo_cmd_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic              avm_writeresponsevalid;
    logic [1:0]        avm_response;

    // Seen from the write master: takes commands, drives the Avalon write.
    modport master (
        input  cmd_valid, cmd_addr, cmd_data,
        input  avm_waitrequest, avm_writeresponsevalid, avm_response,
        output cmd_ready, avm_address, avm_write, avm_writedata
    );

    // Seen from the command producer and the servo slave.
    modport slave (
        output cmd_valid, cmd_addr, cmd_data,
        output avm_waitrequest, avm_writeresponsevalid, avm_response,
        input  cmd_ready, avm_address, avm_write, avm_writedata
    );
endinterface

// File: rtl/servo_cmd_master.sv
// rtl/servo_cmd_master.sv - single-write Avalon-MM master for the servo IP, optional response timeout via SERVO_CMD_MASTER_TIMEOUT_EN
module servo_cmd_master #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    servo_cmd_master_if.master  bus,
    output logic                done,
    output logic                resp_err,
    output logic                timed_out,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              avm_write_q;
    logic [ADDR_W-1:0] avm_address_q;
    logic [DATA_W-1:0] avm_writedata_q;
    logic [7:0]        err_count_inc;
    logic              resp_bad;

    // A timeout window shorter than two cycles cannot be represented.
    if (TIMEOUT_CYC < 2) begin : g_timeout_cyc_check
        $error("servo_cmd_master: TIMEOUT_CYC must be at least 2");
    end

    // Only one command is ever in flight, so ready simply means idle.
    assign bus.cmd_ready     = (state == IDLE);
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;

    assign resp_bad      = (bus.avm_response != 2'b00);
    assign err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

`ifdef SERVO_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic             timed_out_q;
    logic [CNT_W-1:0] tmo_cnt;

    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    // Transfer sequencer: accept command, hold the write until taken, await the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            done            <= 1'b0;
            resp_err        <= 1'b0;
            err_count       <= 8'd0;
`ifdef SERVO_CMD_MASTER_TIMEOUT_EN
            timed_out_q     <= 1'b0;
            tmo_cnt         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        avm_address_q   <= bus.cmd_addr;
                        avm_writedata_q <= bus.cmd_data;
                        avm_write_q     <= 1'b1;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (!bus.avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        state       <= RESP;
`ifdef SERVO_CMD_MASTER_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                RESP: begin
                    // A response arriving on the final timeout cycle still wins.
                    if (bus.avm_writeresponsevalid) begin
                        done     <= 1'b1;
                        resp_err <= resp_bad;
                        if (resp_bad) begin
                            err_count <= err_count_inc;
                        end
`ifdef SERVO_CMD_MASTER_TIMEOUT_EN
                        timed_out_q <= 1'b0;
`endif
                        state <= IDLE;
                    end
`ifdef SERVO_CMD_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        done        <= 1'b1;
                        resp_err    <= 1'b1;
                        timed_out_q <= 1'b1;
                        err_count   <= err_count_inc;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    avm_write_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/servo_cmd_master.md
# servo_cmd_master

Avalon-MM write master that drives the custom servo IP's slave port from a simple command stream. It is used for autonomous servo control and for bring-up without the Nios core. The block accepts one command at a time on a valid/ready interface and issues a single Avalon write. It then waits for the slave's write response, then reports completion, response status and a saturating error count.

## Interface
Parameters:
- ADDR_W, 2: Avalon word-address width.
- DATA_W, 32: write data width.
- TIMEOUT_CYC, 1024: cycles to wait for a write response before abandoning the transfer. Only used with the timeout feature; must be ≥ 2.

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_W  target register address
- cmd_data  in  DATA_W  write data
- avm_address  out  ADDR_W  Avalon address
- avm_write  out  1  Avalon write request
- avm_writedata  out  DATA_W  Avalon write data
- avm_waitrequest  in  1  slave stall
- avm_writeresponsevalid  in  1  write response strobe, active-high
- avm_response  in  2  response code (00 OKAY, nonzero is an error)
- done  out  1  one-cycle pulse when a transfer terminates
- resp_err  out  1  status of the last transfer: set on nonzero response or timeout
- timed_out  out  1  the last transfer ended by timeout
- err_count  out  8  saturating count of failed transfers

## Operation
- FSM states: IDLE, WRITE, RESP.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid = 1, latch cmd_addr and cmd_data into avm_address and avm_writedata, then go to WRITE.
- WRITE:
  - avm_write = 1; address and data are held stable.
  - If avm_waitrequest = 0, the write is accepted; go to RESP.
  - If avm_waitrequest = 1, remain in WRITE with no limit.
- RESP:
  - avm_write = 0.
  - When avm_writeresponsevalid = 1:
    - resp_err is set to 1 if avm_response ≠ 00, otherwise 0.
    - timed_out is set to 0.
    - done pulses for one cycle.
    - Go to IDLE.
- avm_writeresponsevalid is ignored in IDLE and WRITE (stray responses are dropped).
- err_count increments by 1 on every failed termination and saturates at 255. It is cleared only by reset.
- cmd_ready is 0 in WRITE and RESP, so at most one command is in flight. Commands presented while busy are not consumed.
- Reset mid-operation:
  - The FSM returns to IDLE and avm_write drops in the same cycle.
  - The outstanding response is abandoned.
- Reset values:
  - cmd_ready = 1 (combinational from IDLE).
  - avm_write = 0, avm_address = 0, avm_writedata = 0.
  - done = 0, resp_err = 0, timed_out = 0, err_count = 0.

## Timing
- Command accepted on edge N (cmd_valid and cmd_ready both high). avm_write is high in cycle N+1.
- With avm_waitrequest = 0, the write is accepted at the end of N+1, and the FSM is in RESP from N+2.
- Earliest completion: the response is valid in cycle N+2, done is high in N+3, and cmd_ready is high in N+3.
- Minimum command-to-command period: 3 cycles.
- done, resp_err and timed_out are registered. resp_err and timed_out hold their values until the next terminating event.
- avm_address and avm_writedata change only on command acceptance.

## Configuration
- SERVO_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to RESP and increments each cycle in RESP.
  - If the counter reaches TIMEOUT_CYC-1 with no response, the transfer terminates: done pulses, resp_err = 1, timed_out = 1, err_count increments, FSM goes to IDLE.
  - If a response and the timeout occur in the same cycle, the response wins.
- SERVO_CMD_MASTER_TIMEOUT_EN undefined:
  - There is no counter, and RESP waits indefinitely.
  - timed_out is tied to 0.

## Test plan
- Basic write, slave with no waitrequest:
  - Stimulus: cmd addr=1, data=0x0000_00B4; response 00 one cycle after acceptance.
  - Required: avm_write high exactly one cycle; done at N+3; resp_err=0; err_count=0.
- Wait-states:
  - Stimulus: avm_waitrequest held high 5 cycles.
  - Required: avm_write high 6 cycles with address and data stable; cmd_ready low throughout; single done.
- Error response:
  - Stimulus: avm_response=10.
  - Required: resp_err=1, timed_out=0, err_count=1. A following OKAY transfer clears resp_err while err_count stays 1.
- Timeout (macro on, TIMEOUT_CYC=16):
  - Stimulus: no response.
  - Required: done 16 cycles after entering RESP; resp_err=1; timed_out=1. A late response arriving in IDLE is ignored.
- Reset in RESP:
  - Stimulus: assert reset_n=0 one cycle.
  - Required: next cycle avm_write=0, cmd_ready=1, all status outputs 0; no done.
- Saturation:
  - Stimulus: 260 error responses.
  - Required: err_count=255.
